// File: rtl/multiword_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : substractor / multiword_sub_ctrl
// Purpose  : Multi-word subtractor built from one WIDTH-bit slice. The slice
//            is reused once per cycle, LSB chunk first, with a rippled borrow.
// Revision : 1.0 - initial release
// ============================================================================

module substractor #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout
);
    // Widen by one bit; the sign bit of the widened difference is the borrow-out.
    assign {o_bout, o_diff} = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_bin};
endmodule

module multiword_sub_ctrl #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [WIDTH*WORDS-1:0] i_op1,
    input  logic [WIDTH*WORDS-1:0] i_op2,
    input  logic                   i_borrow,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [WIDTH*WORDS-1:0] o_res,
    output logic                   o_borrow
);
    localparam int c_n     = WIDTH * WORDS;
    localparam int c_idx_w = $clog2(WORDS);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(WORDS - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [c_n-1:0]     r_op1;
    logic [c_n-1:0]     r_op2;
    logic               r_bin;
    logic [c_n-1:0]     r_res;
    logic               r_bout;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [31:0]        w_base;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_diff;
    logic               w_bout;

    assign w_last = (r_idx == c_idx_last);
    assign w_base = 32'(r_idx) * 32'(WIDTH);
    assign w_a    = r_op1[w_base +: WIDTH];
    assign w_b    = r_op2[w_base +: WIDTH];

    substractor #(
        .WIDTH (WIDTH)
    ) u_slice (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_bin  (r_bin),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

    // State register; reset drops straight to IDLE without waiting for a clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the load/step strobes and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                o_busy = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Operand capture on accept, then one chunk of result and borrow per RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx  <= '0;
            r_op1  <= '0;
            r_op2  <= '0;
            r_bin  <= 1'b0;
            r_res  <= '0;
            r_bout <= 1'b0;
        end else if (w_load) begin
            r_op1 <= i_op1;
            r_op2 <= i_op2;
            r_bin <= i_borrow;
            r_idx <= '0;
        end else if (w_step) begin
            r_res[w_base +: WIDTH] <= w_diff;
            r_bin                  <= w_bout;
            if (w_last) begin
                r_bout <= w_bout;
            end else begin
                r_idx <= r_idx + c_idx_w'(1);
            end
        end
    end

    assign o_res    = r_res;
    assign o_borrow = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_multiword_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiword_sub_ctrl
// Purpose  : Self-checking bench for multiword_sub_ctrl (WIDTH=4, WORDS=4):
//            directed vectors, start/operand immunity in flight, async reset
//            abort, and a long randomized back-to-back run against a model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_multiword_sub_ctrl;
    localparam int WIDTH = 4;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic         clk     = 1'b0;
    logic         r_rst   = 1'b1;
    logic         r_start = 1'b0;
    logic         r_bin   = 1'b0;
    logic [N-1:0] r_op1   = '0;
    logic [N-1:0] r_op2   = '0;
    logic         w_busy;
    logic         w_done;
    logic [N-1:0] w_res;
    logic         w_bo;

    int total = 0;
    int bad   = 0;

    multiword_sub_ctrl #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) dut (
        .i_clk    (clk),
        .i_rst    (r_rst),
        .i_start  (r_start),
        .i_op1    (r_op1),
        .i_op2    (r_op2),
        .i_borrow (r_bin),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_res    (w_res),
        .o_borrow (w_bo)
    );

    always #5 clk = ~clk;

    // Reference: full-width subtraction in N+1 bits, MSB is the final borrow.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        return {1'b0, a} - {1'b0, b} - (N+1)'(c);
    endfunction

    // Issue one start and wait (bounded) for the done pulse; lat counts cycles after acceptance.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                          output int lat, output logic [N-1:0] res, output logic bo);
        @(negedge clk);
        r_start = 1'b1; r_op1 = a; r_op2 = b; r_bin = c;
        @(negedge clk);
        r_start = 1'b0;
        r_op1 = N'($urandom); r_op2 = N'($urandom); r_bin = 1'($urandom);
        lat = 1;
        while (!w_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = w_res;
        bo  = w_bo;
    endtask

    task automatic test_reset();
        r_rst = 1'b1; r_start = 1'b1; r_op1 = 16'hFFFF; r_op2 = 16'h0001;
        repeat (2) @(negedge clk);
        total++; if (w_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", w_busy); end
        total++; if (w_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", w_done); end
        total++; if (w_res !== 16'h0) begin bad++; $display("FAIL reset_res got=%h want=0000", w_res); end
        total++; if (w_bo !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b want=0", w_bo); end
        r_start = 1'b0; r_rst = 1'b0;
        @(negedge clk);
        total++; if (w_busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy got=%b want=0", w_busy); end
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [3] = '{16'h1234, 16'h0000, 16'h0005};
        logic [N-1:0] tb [3] = '{16'h0034, 16'h0001, 16'h0005};
        logic         tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [N-1:0] er [3] = '{16'h1200, 16'hFFFF, 16'hFFFF};
        logic         eb [3] = '{1'b0, 1'b1, 1'b1};
        int lat; logic [N-1:0] res; logic bo;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], tc[i], lat, res, bo);
            total++; if (lat !== 5) begin bad++; $display("FAIL dir%0d_latency got=%0d want=5", i, lat); end
            total++; if (res !== er[i]) begin bad++; $display("FAIL dir%0d_res got=%h want=%h", i, res, er[i]); end
            total++; if (bo !== eb[i]) begin bad++; $display("FAIL dir%0d_borrow got=%b want=%b", i, bo, eb[i]); end
            @(negedge clk);
            total++; if (w_done !== 1'b0) begin bad++; $display("FAIL dir%0d_done_width got=%b want=0", i, w_done); end
            total++; if (w_busy !== 1'b0) begin bad++; $display("FAIL dir%0d_busy_after got=%b want=0", i, w_busy); end
            total++; if (w_res !== er[i]) begin bad++; $display("FAIL dir%0d_res_hold got=%h want=%h", i, w_res, er[i]); end
        end
    endtask

    task automatic test_ignore_start();
        logic [N:0] exp = model(16'h8000, 16'h0001, 1'b0);
        int ndone = 0; int first = 0; logic [N-1:0] res = '0; logic bo = 1'b0;
        @(negedge clk);
        r_start = 1'b1; r_op1 = 16'h8000; r_op2 = 16'h0001; r_bin = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) r_start = 1'b0;
            if (c == 2) begin r_start = 1'b1; r_op1 = 16'h0000; end
            if (c == 3) r_start = 1'b0;
            if (w_done) begin
                ndone++;
                if (ndone == 1) begin first = c; res = w_res; bo = w_bo; end
            end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", ndone); end
        total++; if (first !== 5) begin bad++; $display("FAIL ign_latency got=%0d want=5", first); end
        total++; if (res !== exp[N-1:0]) begin bad++; $display("FAIL ign_res got=%h want=%h", res, exp[N-1:0]); end
        total++; if (bo !== exp[N]) begin bad++; $display("FAIL ign_borrow got=%b want=%b", bo, exp[N]); end
    endtask

    task automatic test_async_reset();
        int ndone = 0; int lat; logic [N-1:0] res; logic bo;
        @(negedge clk);
        r_start = 1'b1; r_op1 = 16'hABCD; r_op2 = 16'h1234; r_bin = 1'b1;
        @(negedge clk); r_start = 1'b0;
        repeat (2) @(negedge clk);
        #2 r_rst = 1'b1;
        #1;
        total++; if (w_busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", w_busy); end
        total++; if (w_done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", w_done); end
        total++; if (w_res !== 16'h0) begin bad++; $display("FAIL arst_res got=%h want=0000", w_res); end
        total++; if (w_bo !== 1'b0) begin bad++; $display("FAIL arst_borrow got=%b want=0", w_bo); end
        @(negedge clk);
        r_rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (w_done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL arst_no_done got=%0d want=0", ndone); end
        run_op(16'h00FF, 16'h000F, 1'b0, lat, res, bo);
        total++; if (lat !== 5) begin bad++; $display("FAIL arst_new_latency got=%0d want=5", lat); end
        total++; if (res !== 16'h00F0) begin bad++; $display("FAIL arst_new_res got=%h want=00f0", res); end
        total++; if (bo !== 1'b0) begin bad++; $display("FAIL arst_new_borrow got=%b want=0", bo); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [N:0] exp;
        int gap;
        @(negedge clk);
        r_start = 1'b1;
        r_op1 = N'($urandom); r_op2 = N'($urandom); r_bin = 1'($urandom);
        for (int k = 0; k < 1000; k++) begin
            exp = model(r_op1, r_op2, r_bin);
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!w_done && gap < 20);
            total++;
            if (gap !== ((k == 0) ? 5 : 6)) begin
                bad++; $display("FAIL b2b%0d_spacing got=%0d want=%0d", k, gap, (k == 0) ? 5 : 6);
            end
            total++;
            if ({w_bo, w_res} !== exp) begin
                bad++; $display("FAIL b2b%0d_result got=%b_%h want=%b_%h", k, w_bo, w_res, exp[N], exp[N-1:0]);
            end
            // New operands for the next accept, which happens two edges after this done.
            r_op1 = N'($urandom); r_op2 = N'($urandom); r_bin = 1'($urandom);
            if (k == 999) r_start = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
